// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with double-buffered shadow/active registers.
// Shadow registers take host writes; the active set reloads at each period wrap or while idle.
module pwm_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk100,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [3:0]        rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] pwm,
    output logic              period_tick
);

    localparam logic [3:0] ADDR_PRESC = 4'd0;
    localparam logic [3:0] ADDR_TOP   = 4'd1;
    localparam logic [3:0] ADDR_EN    = 4'd2;
    localparam logic [3:0] ADDR_POL   = 4'd3;

    // Shadow (host-visible) registers
    logic [CNT_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0]  top_q,   top_d;
    logic [NUM_CH-1:0] en_q,    en_d;
    logic [NUM_CH-1:0] pol_q,   pol_d;
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];

    // Active registers driving the output logic
    logic [CNT_W-1:0]  presc_act_q;
    logic [CNT_W-1:0]  top_act_q;
    logic [NUM_CH-1:0] en_act_q;
    logic [NUM_CH-1:0] pol_act_q;
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];

    // Counters and registered outputs
    logic [CNT_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              tick_q,      tick_d;
    logic [NUM_CH-1:0] pwm_q,       pwm_d;
    logic [CNT_W-1:0]  rd_q,        rd_d;

    logic running_s;
    logic presc_hit_s;
    logic wrap_s;
    logic commit_s;

    // Shadow register write decode; mask bits above NUM_CH are dropped
    always_comb begin
        presc_d = presc_q;
        top_d   = top_q;
        en_d    = en_q;
        pol_d   = pol_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
        end
        if (wr_en) begin
            case (wr_addr)
                ADDR_PRESC: presc_d = wr_data;
                ADDR_TOP:   top_d   = wr_data;
                ADDR_EN:    en_d    = wr_data[NUM_CH-1:0];
                ADDR_POL:   pol_d   = wr_data[NUM_CH-1:0];
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (wr_addr == 4'(4 + i)) begin
                            duty_d[i] = wr_data;
                        end else begin
                            duty_d[i] = duty_q[i];
                        end
                    end
                end
            endcase
        end else begin
            presc_d = presc_q;
        end
    end

    // Readback mux over the shadow set; unmapped addresses read zero
    always_comb begin
        rd_d = '0;
        case (rd_addr)
            ADDR_PRESC: rd_d = presc_q;
            ADDR_TOP:   rd_d = top_q;
            ADDR_EN:    rd_d = CNT_W'(en_q);
            ADDR_POL:   rd_d = CNT_W'(pol_q);
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (rd_addr == 4'(4 + i)) begin
                        rd_d = duty_q[i];
                    end else begin
                        rd_d = rd_d;
                    end
                end
            end
        endcase
    end

    // Prescaler and period counter; both are held at zero while idle
    always_comb begin
        running_s   = |en_act_q;
        presc_hit_s = (presc_cnt_q == presc_act_q);
        wrap_s      = running_s && presc_hit_s && (cnt_q == top_act_q);
        commit_s    = !running_s || wrap_s;
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        if (!running_s) begin
            presc_cnt_d = '0;
            cnt_d       = '0;
            tick_d      = 1'b0;
        end else if (presc_hit_s) begin
            presc_cnt_d = '0;
            if (cnt_q == top_act_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                tick_d = 1'b0;
            end
        end else begin
            presc_cnt_d = presc_cnt_q + CNT_W'(1);
            cnt_d       = cnt_q;
            tick_d      = 1'b0;
        end
    end

    // Compare and polarity stage; registered so pwm lags cnt by one cycle
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (en_act_q[i] && (cnt_q < duty_act_q[i])) ^ pol_act_q[i];
        end
    end

    // State registers; commit samples the pre-write shadow values
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            presc_q     <= '0;
            top_q       <= {CNT_W{1'b1}};
            en_q        <= '0;
            pol_q       <= '0;
            presc_act_q <= '0;
            top_act_q   <= {CNT_W{1'b1}};
            en_act_q    <= '0;
            pol_act_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            pwm_q       <= '0;
            rd_q        <= '0;
        end else begin
            presc_q <= presc_d;
            top_q   <= top_d;
            en_q    <= en_d;
            pol_q   <= pol_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
            if (commit_s) begin
                presc_act_q <= presc_q;
                top_act_q   <= top_q;
                en_act_q    <= en_q;
                pol_act_q   <= pol_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_q[i] <= duty_q[i];
                end
            end
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
            rd_q        <= rd_d;
        end
    end

    assign rd_data     = rd_q;
    assign pwm         = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of PWM channels, legal range 1..8.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the period/duty counter width, fixed at 8 in this generation to match byte registers.
REQ-003 The block SHALL have port clk100, input, 1 bit: 100 MHz clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle when high.
REQ-006 The block SHALL have port wr_addr, input, 4 bits: register write address.
REQ-007 The block SHALL have port wr_data, input, 8 bits: register write data.
REQ-008 The block SHALL have port rd_addr, input, 4 bits: register read address.
REQ-009 The block SHALL have port rd_data, output, 8 bits: registered readback of the shadow register at rd_addr.
REQ-010 The block SHALL have port pwm, output, NUM_CH bits: registered PWM outputs.
REQ-011 The block SHALL have port period_tick, output, 1 bit: one-cycle pulse at each period wrap.

Function
REQ-012 The register map SHALL be: 0 PRESC, 1 TOP, 2 EN mask (bit i = channel i), 3 POL mask, 4+i DUTY[i] for i < NUM_CH; mask bits at or above NUM_CH SHALL be ignored on write and read as 0.
REQ-013 A write to an unmapped address SHALL be ignored with no side effect.
REQ-014 Writes SHALL update shadow registers only; the active registers drive the output logic.
REQ-015 rd_data SHALL equal the shadow value at the rd_addr sampled one cycle earlier; unmapped addresses SHALL read 0; a same-cycle write SHALL NOT be visible until the following read.
REQ-016 Prescaler: presc_cnt SHALL count 0..PRESC_active; a tick SHALL be asserted in the cycle presc_cnt == PRESC_active, and presc_cnt SHALL return to 0 on the next cycle; PRESC = 0 SHALL tick every cycle.
REQ-017 Period counter: on each tick, cnt SHALL increment; on a tick with cnt == TOP_active, cnt SHALL wrap to 0 and period_tick SHALL be 1 in the following cycle only; a period SHALL be (TOP+1)*(PRESC+1) cycles.
REQ-018 Commit: at each wrap, all active registers SHALL load from the shadow registers simultaneously.
REQ-019 Commit with a same-cycle write: the commit SHALL take the pre-write shadow value, and the new write SHALL take effect at the next wrap.
REQ-020 Idle: while EN_active == 0, the shadow registers SHALL be copied to the active registers every cycle, cnt and presc_cnt SHALL be held at 0, and period_tick SHALL stay 0.
REQ-021 Output rule: raw[i] = EN_active[i] AND (cnt < DUTY_active[i]); pwm[i] SHALL be registered as raw[i] XOR POL_active[i], giving one cycle of latency from cnt.
REQ-022 Duty boundaries: DUTY = 0 SHALL give constant inactive output; DUTY > TOP SHALL give constant active output; DUTY = TOP SHALL be active for TOP of TOP+1 counts.
REQ-023 A disabled channel SHALL output its idle level, POL_active[i].
REQ-024 Reducing TOP below the current cnt SHALL NOT cause runaway counting, because TOP only changes at a wrap or in idle.
REQ-025 Comparisons SHALL be unsigned CNT_W-bit; no counter SHALL overflow silently, since cnt never exceeds TOP_active.

Reset
REQ-026 On reset_n = 0 at a clock edge, shadow and active registers SHALL load: PRESC 0, TOP 0xFF, EN 0, POL 0, DUTY 0.
REQ-027 On reset, cnt, presc_cnt, pwm, period_tick and rd_data SHALL be 0.
REQ-028 Reset SHALL take priority over any same-cycle write.
REQ-029 Reset asserted mid-period SHALL abort the period immediately, and outputs SHALL be 0 in the cycle after the reset edge.

Verification
REQ-030 Write TOP=9, PRESC=0, DUTY0=3, then EN=0x1 -> pwm[0] high 3 cycles, low 7 cycles, repeating; period_tick once every 10 cycles.
REQ-031 With REQ-030 running, write DUTY0=7 mid-period -> the current period is unchanged, the first period after the next period_tick is 7 high / 3 low, and an immediate readback of address 4 returns 7.
REQ-032 With TOP=9 and PRESC=4, DUTY1=0, DUTY2=10, POL=0x2, EN=0x6 -> period = 50 cycles; pwm[1] constant 1 (inverted 0% duty); pwm[2] constant 1 (DUTY > TOP); pwm[0] holds POL idle 0.
REQ-033 Write to address 4 in the exact cycle of a wrap -> the old duty is used for the new period and the new duty applies from the following wrap.
REQ-034 Write to address 15 (with NUM_CH=4) and EN=0xF0 -> no register change, EN reads back 0, and all outputs remain idle.
REQ-035 Assert reset_n=0 for 1 cycle mid-period with a write present -> all registers return to their reset values, pwm=0, period_tick=0, rd_data=0, and the write is discarded.
